// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch controller and its fetch queue.
// Optional build macro: IFETCH_PERF_EN (adds fetch/stall counters to the top).
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INC = 4;

  // Number of fetched-but-not-decoded entries held in front of decode.
  localparam int unsigned QUEUE_DEPTH = 2;

  // Saturating increment for the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO between the instruction memory and decode.
// Control state (pointers, count) is reset; entry storage is not, because the
// head is only observed while count is nonzero.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter type entry_t = logic [41:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t mem [QUEUE_DEPTH];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   do_pop;

  // A pop on an empty queue is ignored rather than corrupting the pointers.
  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything including a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// CPU front-end fetch controller: owns the PC, drives the instruction memory
// address, queues fetched words in fetch_queue and hands them to decode over a
// valid/ready handshake. Redirects flush the queue and reload the PC.
// Optional build macro: IFETCH_PERF_EN adds FetchCount/StallCount outputs.
module instr_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              HaltReq,
  input  logic              RedirectValid,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [ADDR_W-1:0] ImAddr,
  input  logic [DATA_W-1:0] ImData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              Running,
  output logic              Misalign
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      tail_in;
  logic              pop;
  logic              push;
  logic              has_room;

  assign OutValid = (count != 2'd0);
  assign pop      = OutValid && OutReady;
  // A full queue can still accept the new word when its head leaves this cycle.
  assign has_room = (count < 2'(QUEUE_DEPTH)) || pop;
  assign push     = (state == ST_RUN) && !RedirectValid && has_room;
  assign tail_in  = '{pc: pc, instr: ImData};

  assign ImAddr   = pc;
  assign Running  = (state == ST_RUN);
  assign Instr    = OutValid ? head.instr : '0;
  assign InstrPC  = OutValid ? head.pc    : '0;

  fetch_queue #(
    .entry_t (fetch_entry_t)
  ) u_queue (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .flush (RedirectValid),
    .din   (tail_in),
    .head  (head),
    .count (count)
  );

  // Run-control transitions; halt takes precedence over a simultaneous start.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (Start)   state_nxt = ST_RUN;
      ST_RUN:    if (HaltReq) state_nxt = ST_HALTED;
      ST_HALTED: if (Start)   state_nxt = ST_RUN;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // PC update: redirect reloads a word-aligned target, otherwise advance per fetch (wraps).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)              pc <= RESET_PC;
    else if (RedirectValid) pc <= {RedirectPC[ADDR_W-1:2], 2'b00};
    else if (push)          pc <= pc + ADDR_W'(PC_INC);
  end

  // Sticky flag for any redirect target that was not word-aligned.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                         Misalign <= 1'b0;
    else if (RedirectValid && (RedirectPC[1:0] != 2'b00)) Misalign <= 1'b1;
  end

`ifdef IFETCH_PERF_EN
  // Saturating counts of fetches and of RUN cycles blocked by a full queue.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount <= 32'd0;
      StallCount <= 32'd0;
    end else begin
      if (push) FetchCount <= sat_inc32(FetchCount);
      if ((state == ST_RUN) && (count == 2'(QUEUE_DEPTH)) && !pop)
        StallCount <= sat_inc32(StallCount);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl. Instruction memory word k holds
// 32'hC0DE0000 + k, so expected Instr values follow directly from InstrPC.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic              HaltReq;
  logic              RedirectValid;
  logic [ADDR_W-1:0] RedirectPC;
  logic [ADDR_W-1:0] ImAddr;
  logic [DATA_W-1:0] ImData;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic              Running;
  logic              Misalign;
`ifdef IFETCH_PERF_EN
  logic [31:0]       FetchCount;
  logic [31:0]       StallCount;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign ImData = 32'hC0DE_0000 | {24'd0, ImAddr[9:2]};

  instr_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (10'd0)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .HaltReq       (HaltReq),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .ImAddr        (ImAddr),
    .ImData        (ImData),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .Instr         (Instr),
    .InstrPC       (InstrPC),
    .Running       (Running),
    .Misalign      (Misalign)
`ifdef IFETCH_PERF_EN
    ,
    .FetchCount    (FetchCount),
    .StallCount    (StallCount)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset         = 1'b1;
    Start         = 1'b0;
    HaltReq       = 1'b0;
    RedirectValid = 1'b0;
    RedirectPC    = '0;
    OutReady      = 1'b0;
    tick;
    Reset = 1'b0;
  endtask

  task automatic start_run;
    Start = 1'b1;
    tick;
    Start = 1'b0;
  endtask

  task automatic redirect(input logic [ADDR_W-1:0] target);
    RedirectValid = 1'b1;
    RedirectPC    = target;
    tick;
    RedirectValid = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset;
    check_eq("rst_valid",    32'(OutValid), 32'd0);
    check_eq("rst_instr",    Instr,         32'd0);
    check_eq("rst_instrpc",  32'(InstrPC),  32'd0);
    check_eq("rst_running",  32'(Running),  32'd0);
    check_eq("rst_misalign", 32'(Misalign), 32'd0);
    check_eq("rst_imaddr",   32'(ImAddr),   32'd0);

    // Streaming fetch with decode always ready
    OutReady = 1'b1;
    start_run;
    check_eq("start_running", 32'(Running),  32'd1);
    check_eq("start_valid0",  32'(OutValid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check_eq("stream_valid", 32'(OutValid), 32'd1);
      check_eq("stream_pc",    32'(InstrPC),  32'(k * 4));
      check_eq("stream_instr", Instr,         32'hC0DE_0000 + 32'(k));
    end

    // Decode stalled: queue fills, PC holds, then drains in order
    do_reset;
    start_run;
    repeat (4) tick;
    check_eq("stall_imaddr", 32'(ImAddr),  32'h8);
    check_eq("stall_head",   32'(InstrPC), 32'h0);
    tick;
`ifdef IFETCH_PERF_EN
    check_eq("stall_count", StallCount, 32'd3);
    check_eq("fetch_count", FetchCount, 32'd2);
`endif
    check_eq("stall_imaddr2", 32'(ImAddr),  32'h8);
    check_eq("drain_pc0",     32'(InstrPC), 32'h0);
    OutReady = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick;
      check_eq("drain_pc",    32'(InstrPC), 32'(k * 4));
      check_eq("drain_instr", Instr,        32'hC0DE_0000 + 32'(k));
    end

    // Redirect while full, with a pop offered in the same cycle
    do_reset;
    start_run;
    tick;
    tick;
    check_eq("full_head", 32'(InstrPC), 32'h0);
    OutReady = 1'b1;
    redirect(10'h050);
    check_eq("redir_valid",   32'(OutValid), 32'd0);
    check_eq("redir_instrpc", 32'(InstrPC),  32'd0);
    check_eq("redir_instr",   Instr,         32'd0);
    check_eq("redir_imaddr",  32'(ImAddr),   32'h50);
    tick;
    check_eq("redir_tgt_valid", 32'(OutValid), 32'd1);
    check_eq("redir_tgt_pc",    32'(InstrPC),  32'h50);
    check_eq("redir_tgt_instr", Instr,         32'hC0DE_0014);
    tick;
    check_eq("redir_next_pc", 32'(InstrPC), 32'h54);

    // Misaligned redirect sets a sticky flag
    redirect(10'h052);
    check_eq("mis_imaddr", 32'(ImAddr),   32'h50);
    check_eq("mis_flag",   32'(Misalign), 32'd1);
    redirect(10'h100);
    check_eq("mis_sticky",  32'(Misalign), 32'd1);
    check_eq("mis_imaddr2", 32'(ImAddr),   32'h100);
    tick;
    check_eq("aligned_pc",    32'(InstrPC), 32'h100);
    check_eq("aligned_instr", Instr,        32'hC0DE_0040);

    // PC wrap from the top word back to zero
    redirect(10'h3F8);
    tick;
    check_eq("wrap_pc0", 32'(InstrPC), 32'h3F8);
    tick;
    check_eq("wrap_pc1",    32'(InstrPC), 32'h3FC);
    check_eq("wrap_instr1", Instr,        32'hC0DE_00FF);
    tick;
    check_eq("wrap_pc2",    32'(InstrPC), 32'h000);
    check_eq("wrap_instr2", Instr,        32'hC0DE_0000);

    // Halt with a full queue (halt beats a simultaneous start), drain, resume
    do_reset;
    start_run;
    tick;
    tick;
    HaltReq = 1'b1;
    Start   = 1'b1;
    tick;
    HaltReq = 1'b0;
    Start   = 1'b0;
    check_eq("halt_running", 32'(Running),  32'd0);
    check_eq("halt_valid",   32'(OutValid), 32'd1);
    check_eq("halt_head",    32'(InstrPC),  32'h0);
    check_eq("halt_imaddr",  32'(ImAddr),   32'h8);
    OutReady = 1'b1;
    tick;
    check_eq("halt_drain_pc",    32'(InstrPC), 32'h4);
    check_eq("halt_drain_instr", Instr,        32'hC0DE_0001);
    tick;
    check_eq("halt_empty",   32'(OutValid), 32'd0);
    check_eq("halt_pc_hold", 32'(ImAddr),   32'h8);
    start_run;
    check_eq("resume_running", 32'(Running),  32'd1);
    check_eq("resume_valid0",  32'(OutValid), 32'd0);
    tick;
    check_eq("resume_valid", 32'(OutValid), 32'd1);
    check_eq("resume_pc",    32'(InstrPC),  32'h8);

    // Asynchronous reset between clock edges
    redirect(10'h052);
    tick;
    check_eq("pre_rst_misalign", 32'(Misalign), 32'd1);
    check_eq("pre_rst_valid",    32'(OutValid), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("async_valid",    32'(OutValid), 32'd0);
    check_eq("async_running",  32'(Running),  32'd0);
    check_eq("async_imaddr",   32'(ImAddr),   32'd0);
    check_eq("async_instrpc",  32'(InstrPC),  32'd0);
    check_eq("async_instr",    Instr,         32'd0);
    check_eq("async_misalign", 32'(Misalign), 32'd0);
    tick;
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
